// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - multi-generator PWM with prescaler, edge/centre counting and shadowed config
module pwm_multi_gen #(
    parameter int NUM_OUT = 8,
    parameter int NUM_GEN = 4,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [NUM_OUT-1:0]       en_out,
    input  logic [NUM_OUT-1:0]       en_pwm_out,
    input  logic [NUM_OUT*SEL_W-1:0] out_sel,
    input  logic [NUM_OUT-1:0]       invert,
    input  logic [PRESC_W-1:0]       prescale,
    input  logic [CNT_W-1:0]         period,
    input  logic [NUM_GEN*CNT_W-1:0] duty,
    input  logic                     center,
    input  logic                     cfg_load,
    output logic                     load_pending,
    output logic                     period_start,
    output logic [NUM_OUT-1:0]       out
);

    localparam int SEL_N = 2 ** SEL_W;

    logic [PRESC_W-1:0]       psc;
    logic [CNT_W-1:0]         cnt;
    logic                     dir_down;
    logic [CNT_W-1:0]         p_act;
    logic [NUM_GEN*CNT_W-1:0] duty_act;
    logic                     center_act;

    logic                     tick;
    logic                     wrap;
    logic [CNT_W-1:0]         cnt_nxt;
    logic                     dir_nxt;
    logic [SEL_N-1:0]         pwm;
    logic [SEL_N-1:0]         sel_ok;
    logic [NUM_OUT-1:0]       out_nxt;

    assign tick = run && (psc == prescale);

    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir_down;
        wrap    = 1'b0;
        if (tick) begin
            if (!center_act) begin
                if (cnt >= p_act) begin
                    cnt_nxt = '0;
                    wrap    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (!dir_down) begin
                if (cnt < p_act) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (p_act == '0) begin
                    // Degenerate centre period: stay at zero and wrap on every tick.
                    cnt_nxt = '0;
                    wrap    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    dir_nxt = 1'b1;
                end
            end else begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    cnt_nxt = (p_act == '0) ? '0 : CNT_W'(1);
                    dir_nxt = 1'b0;
                    wrap    = 1'b1;
                end
            end
        end
    end

    // Unpopulated select codes compare as 0 and are flagged invalid for the output mux.
    for (genvar g = 0; g < SEL_N; g++) begin : g_gen
        if (g < NUM_GEN) begin : g_real
            assign pwm[g]    = (cnt < duty_act[g*CNT_W +: CNT_W]);
            assign sel_ok[g] = 1'b1;
        end else begin : g_none
            assign pwm[g]    = 1'b0;
            assign sel_ok[g] = 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
        logic [SEL_W-1:0] sel;
        assign sel = out_sel[i*SEL_W +: SEL_W];
        always_comb begin
            out_nxt[i] = en_out[i];
            if (en_out[i] && en_pwm_out[i]) begin
                out_nxt[i] = sel_ok[sel] ? (pwm[sel] ^ invert[i]) : invert[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc          <= '0;
            cnt          <= '0;
            dir_down     <= 1'b0;
            p_act        <= '1;
            duty_act     <= '0;
            center_act   <= 1'b0;
            load_pending <= 1'b0;
            period_start <= 1'b0;
            out          <= '0;
        end else if (!run) begin
            // Stopped: active registers track the inputs directly.
            psc          <= '0;
            cnt          <= '0;
            dir_down     <= 1'b0;
            p_act        <= period;
            duty_act     <= duty;
            center_act   <= center;
            load_pending <= 1'b0;
            period_start <= 1'b0;
            out          <= out_nxt;
        end else begin
            psc          <= tick ? '0 : psc + 1'b1;
            period_start <= wrap;
            out          <= out_nxt;
            if (wrap && load_pending) begin
                p_act        <= period;
                duty_act     <= duty;
                center_act   <= center;
                cnt          <= '0;
                dir_down     <= 1'b0;
                load_pending <= 1'b0;
            end else begin
                cnt      <= cnt_nxt;
                dir_down <= dir_nxt;
                if (cfg_load) begin
                    load_pending <= 1'b1;
                end
            end
        end
    end

endmodule
